// File: rtl/serial_receiver_pkg.sv
// Shared state encodings and default bit-timing constants for the serial receiver.
package serial_receiver_pkg;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_WAIT_ACK,
        O_WAIT_REL
    } out_state_t;

endpackage

// File: rtl/rxd_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the p domain.
module rxd_sync (
    input  logic p,
    input  logic reset_,
    input  logic rxd,
    output logic rxd_s
);

    logic meta_q;

    // Both stages reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge p) begin
        if (!reset_) begin
            meta_q <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            meta_q <= rxd;
            rxd_s  <= meta_q;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// 8N1-style serial receiver with a 4-phase dav_/rfd delivery handshake.
//
// Receive FSM
//   state   | meaning
//   R_IDLE  | line idle, waiting for a falling edge on rxd_s
//   R_START | timing to mid start bit; high there means a false start
//   R_DATA  | sampling DATA_BITS data bits at mid-cell, LSB first
//   R_STOP  | sampling the stop bit; deliver, flag overrun, or flag framing error
//   R_BREAK | framing error seen, waiting for the line to return high
//
// Output FSM
//   state      | meaning
//   O_IDLE     | no byte pending, dav_=1
//   O_WAIT_ACK | byte presented, dav_=0, waiting for rfd=0
//   O_WAIT_REL | consumer took it, dav_=1, waiting for rfd=1
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 p,
    input  logic                 reset_,
    input  logic                 rxd,
    input  logic                 rfd,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 dav_,
    output logic                 ferr,
    output logic                 ovr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_NB = NW'(DATA_BITS - 1);

    logic rxd_s;

    rx_state_t            rx_q,   rx_d;
    out_state_t           out_q,  out_d;
    logic [CW-1:0]        cnt_q,  cnt_d;
    logic [NW-1:0]        nb_q,   nb_d;
    logic [DATA_BITS-1:0] sh_q,   sh_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q,  ovr_d;

    rxd_sync u_sync (
        .p      (p),
        .reset_ (reset_),
        .rxd    (rxd),
        .rxd_s  (rxd_s)
    );

    always_ff @(posedge p) begin
        if (!reset_) begin
            rx_q   <= R_IDLE;
            out_q  <= O_IDLE;
            cnt_q  <= '0;
            nb_q   <= '0;
            sh_q   <= '0;
            byte_q <= '0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            rx_q   <= rx_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            nb_q   <= nb_d;
            sh_q   <= sh_d;
            byte_q <= byte_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        rx_d   = rx_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        nb_d   = nb_q;
        sh_d   = sh_q;
        byte_d = byte_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;

        case (out_q)
            O_WAIT_ACK: if (!rfd) out_d = O_WAIT_REL;
            O_WAIT_REL: if (rfd)  out_d = O_IDLE;
            default:    out_d = out_q;
        endcase

        case (rx_q)
            R_IDLE: begin
                if (!rxd_s) begin
                    cnt_d = '0;
                    rx_d  = R_START;
                end
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    nb_d  = '0;
                    rx_d  = rxd_s ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    sh_d                = sh_q >> 1;
                    sh_d[DATA_BITS-1]   = rxd_s;
                    cnt_d               = '0;
                    nb_d                = nb_q + 1'b1;
                    if (nb_q == LAST_NB) rx_d = R_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                        rx_d   = R_BREAK;
                    end else begin
                        rx_d = R_IDLE;
                        // A byte still held by the consumer wins; the new one is dropped.
                        if (out_q == O_IDLE) begin
                            byte_d = sh_q;
                            out_d  = O_WAIT_ACK;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_BREAK: begin
                if (rxd_s) rx_d = R_IDLE;
            end
            default: rx_d = R_IDLE;
        endcase
    end

    assign byte_out = byte_q;
    assign dav_     = (out_q != O_WAIT_ACK);
    assign ferr     = ferr_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Randomized scoreboard bench for serial_receiver at CLKS_PER_BIT=4, DATA_BITS=8.
module tb_serial_receiver;

    localparam int DB  = 8;
    localparam int CPB = 4;
    // Edges from the first low sample of rxd to dav_ low, counting that edge as one.
    localparam int LAT = 2 + CPB / 2 + DB * CPB + CPB + 1;

    logic          p      = 1'b0;
    logic          reset_ = 1'b0;
    logic          rxd    = 1'b1;
    logic          rfd    = 1'b1;
    logic [DB-1:0] byte_out;
    logic          dav_;
    logic          ferr;
    logic          ovr;

    serial_receiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
        .p        (p),
        .reset_   (reset_),
        .rxd      (rxd),
        .rfd      (rfd),
        .byte_out (byte_out),
        .dav_     (dav_),
        .ferr     (ferr),
        .ovr      (ovr)
    );

    always #5 p = ~p;

    int cyc = 0;
    always @(posedge p) cyc++;

    typedef struct {
        logic [DB-1:0] data;
        int            t_exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   ack_en   = 1'b1;
    bit   exp_ferr = 1'b0;
    bit   exp_ovr  = 1'b0;
    bit   unacked  = 1'b0;
    int   ferr_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a frame with a good stop bit is delivered unless the previous
    // byte is still unacknowledged (overrun); a bad stop bit only raises ferr.
    task automatic frame(input logic [DB-1:0] d, input logic stop, input int stop_cells,
                         input bit modeled, input int gap);
        int t;
        @(negedge p);
        t = cyc;
        if (modeled) begin
            if (stop) begin
                if (unacked) exp_ovr = 1'b1;
                else begin
                    q.push_back('{d, t + LAT});
                    if (!ack_en) unacked = 1'b1;
                end
            end else begin
                exp_ferr = 1'b1;
            end
        end
        rxd = 1'b0;
        repeat (CPB) @(negedge p);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge p);
        end
        rxd = stop;
        repeat (stop_cells * CPB) @(negedge p);
        rxd = 1'b1;
        repeat (gap) @(negedge p);
    endtask

    task automatic drain(input string name);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge p);
            ok = (q.size() == 0) && (dav_ === 1'b1);
            n++;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_out"}, byte_out, 0);
        check({tag, "_dav_"},     dav_,     1);
        check({tag, "_ferr"},     ferr,     0);
        check({tag, "_ovr"},      ovr,      0);
    endtask

    // Monitor: every falling dav_ must match the oldest expected byte and its timing.
    logic dav_prev  = 1'b1;
    logic ferr_prev = 1'b0;
    always @(negedge p) begin
        exp_t e;
        if (reset_) begin
            if (dav_prev && !dav_) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_delivery: byte_out=0x%0h at cycle %0d, required no delivery",
                             byte_out, cyc);
                end else begin
                    e = q.pop_front();
                    check("byte_out", byte_out, e.data);
                    n_cmp++;
                    if (cyc < e.t_exp - 1 || cyc > e.t_exp + 1) begin
                        n_bad++;
                        $display("FAIL latency: dav_ fell at cycle %0d, required %0d +/-1", cyc, e.t_exp);
                    end
                end
            end
            if (!ferr_prev && ferr) ferr_rises++;
        end
        dav_prev  = dav_;
        ferr_prev = ferr;
    end

    // Consumer: answers each dav_ with a 4-phase handshake when enabled.
    initial begin
        forever begin
            @(negedge p);
            if (ack_en && reset_ && dav_ === 1'b0) begin
                repeat ($urandom_range(0, 2)) @(negedge p);
                rfd = 1'b0;
                @(negedge p);
                check("dav_release", dav_, 1);
                repeat ($urandom_range(0, 2)) @(negedge p);
                rfd = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int n;

        reset_ = 1'b0;
        repeat (3) @(negedge p);
        check_reset_values("reset");
        reset_ = 1'b1;
        repeat (3) @(negedge p);

        frame(8'hA5, 1'b1, 1, 1'b1, 10);
        drain("drain_a5");
        check("a5_ferr", ferr, 0);
        check("a5_ovr",  ovr,  0);

        @(negedge p); rxd = 1'b0;
        @(negedge p); rxd = 1'b1;
        repeat (12) @(negedge p);
        check("glitch_dav_", dav_, 1);
        frame(8'h3C, 1'b1, 1, 1'b1, 8);
        drain("drain_3c");

        frame(8'h81, 1'b0, 2, 1'b1, 8);
        check("ferr_81", ferr, 1);
        check("ferr_81_dav_", dav_, 1);
        frame(8'h42, 1'b1, 1, 1'b1, 8);
        drain("drain_42");
        check("ferr_sticky", ferr, 1);
        check("ovr_after_42", ovr, 0);

        ack_en = 1'b0;
        frame(8'h11, 1'b1, 1, 1'b1, 0);
        frame(8'h22, 1'b1, 1, 1'b1, 8);
        check("ovr_byte_out", byte_out, 8'h11);
        check("ovr_dav_",     dav_,     0);
        check("ovr_flag",     ovr,      exp_ovr);
        ack_en = 1'b1;
        n = 0;
        while (n < 50 && dav_ !== 1'b1) begin
            @(negedge p);
            n++;
        end
        repeat (6) @(negedge p);
        unacked = 1'b0;
        drain("drain_ovr");

        fork
            frame(8'hFF, 1'b1, 1, 1'b0, 8);
            begin
                repeat (22) @(negedge p);
                reset_ = 1'b0;
                repeat (2) @(negedge p);
                reset_ = 1'b1;
                @(negedge p);
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
                unacked  = 1'b0;
                check_reset_values("midframe");
            end
        join
        repeat (4) @(negedge p);
        check("midframe_no_delivery", dav_, 1);
        frame(8'h5A, 1'b1, 1, 1'b1, 8);
        drain("drain_5a");

        r0 = ferr_rises;
        @(negedge p);
        rxd = 1'b0;
        exp_ferr = 1'b1;
        repeat (30 * CPB) @(negedge p);
        rxd = 1'b1;
        repeat (8) @(negedge p);
        check("break_ferr",   ferr, 1);
        check("break_rises",  ferr_rises - r0, 1);
        check("break_dav_",   dav_, 1);
        frame(8'h77, 1'b1, 1, 1'b1, 8);
        drain("drain_77");

        reset_ = 1'b0;
        repeat (2) @(negedge p);
        reset_ = 1'b1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        @(negedge p);
        for (int i = 0; i < 24; i++) begin
            frame(8'($urandom), ($urandom_range(0, 7) != 0), 1, 1'b1, $urandom_range(2, 10));
        end
        drain("drain_random");
        check("random_ferr", ferr, exp_ferr);
        check("random_ovr",  ovr,  exp_ovr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
